// File: rtl/multicycle_controller_if.sv
// Memory request/ready handshake between the multi-cycle controller and the
// shared instruction/data memory.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS subset CPU.
// Drives all datapath enables and mux selects; memory stalls via mem_ready.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           reset,
  multicycle_controller_if.master        mem,
  input  logic [5:0]                     opcode,
  input  logic [5:0]                     funct,
  input  logic                           zero,
  output logic                           ir_we,
  output logic                           pc_we,
  output logic [1:0]                     pc_src,
  output logic                           reg_we,
  output logic [1:0]                     reg_dst,
  output logic [1:0]                     mem_to_reg,
  output logic [2:0]                     alu_op,
  output logic [1:0]                     alu_src_b,
  output logic [2:0]                     state,
  output logic                           retire,
  output logic                           illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic       req_c, we_c;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R:    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {alu_op, alu_src_b} for the latched instruction.
  function automatic logic [4:0] alu_ctl(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R: begin
        case (fn)
          FN_SUB:  return {3'b001, 2'b00};
          FN_SLT:  return {3'b010, 2'b00};
          default: return {3'b000, 2'b00};
        endcase
      end
      OP_BEQ, OP_BNE:        return {3'b001, 2'b00};
      OP_XORI:               return {3'b011, 2'b10};
      OP_ADDI, OP_LW, OP_SW: return {3'b000, 2'b01};
      default:               return {3'b000, 2'b00};
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_c      = 1'b0;
    we_c       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_op     = 3'b000;
    alu_src_b  = 2'b00;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        ir_we = mem.mem_ready;
        pc_we = mem.mem_ready;
        if (mem.mem_ready) state_d = DECODE;
      end
      // Live decoder fields here: the latched copy only becomes valid next cycle.
      DECODE: begin
        state_d = EXEC;
        if (!is_legal(opcode, funct)) begin
          illegal = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (opcode == OP_J || opcode == OP_JAL) begin
          pc_we   = 1'b1;
          pc_src  = 2'b10;
          retire  = 1'b1;
          state_d = FETCH;
          if (opcode == OP_JAL) begin
            reg_we     = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end else if (opcode == OP_R && funct == FN_JR) begin
          pc_we   = 1'b1;
          pc_src  = 2'b11;
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        {alu_op, alu_src_b} = alu_ctl(op_q, fn_q);
        case (op_q)
          OP_BEQ, OP_BNE: begin
            pc_we   = (op_q == OP_BEQ) ? zero : !zero;
            pc_src  = 2'b01;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_LW, OP_SW: state_d = MEM;
          default:      state_d = WB;
        endcase
      end
      MEM: begin
        req_c     = 1'b1;
        we_c      = (op_q == OP_SW);
        alu_op    = 3'b000;
        alu_src_b = 2'b01;
        if (mem.mem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        {alu_op, alu_src_b} = alu_ctl(op_q, fn_q);
        reg_we     = 1'b1;
        reg_dst    = (op_q == OP_R) ? 2'b01 : 2'b00;
        mem_to_reg = (op_q == OP_LW) ? 2'b01 : 2'b00;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset quiesces every output immediately, abandoning any memory access.
    if (reset) begin
      req_c      = 1'b0;
      we_c       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      reg_we     = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_op     = 3'b000;
      alu_src_b  = 2'b00;
      retire     = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign mem.mem_req = req_c;
  assign mem.mem_we  = we_c;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle checks of every output
// against hand-computed values for each instruction class.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       ir_we, pc_we, reg_we, retire, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op, state;
  int         checks = 0;
  int         failures = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus.master),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .alu_src_b  (alu_src_b),
    .state      (state),
    .retire     (retire),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Order: state req we ir_we pc_we pc_src reg_we reg_dst m2r alu_op src_b retire illegal
  task automatic chk(input string tag, input logic [2:0] st, input logic req, input logic we,
                     input logic irw, input logic pcw, input logic [1:0] pcs, input logic rw,
                     input logic [1:0] rd, input logic [1:0] m2r, input logic [2:0] alu,
                     input logic [1:0] sb, input logic ret, input logic ill);
    logic [20:0] obs, exp;
    #1;
    obs = {state, bus.mem_req, bus.mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_op, alu_src_b, retire, illegal};
    exp = {st, req, we, irw, pcw, pcs, rw, rd, m2r, alu, sb, ret, ill};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag);
    bus.mem_ready = 1'b1;
    chk(tag, 3'd0, 1, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    tick();
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; bus.mem_ready = 1'b0;
    tick(); tick();
    chk("reset_idle", 3'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    reset = 1'b0;

    // SW interrupted by reset while stalled in MEM
    fetch("sw_fetch");
    opcode = 6'b101011;
    chk("sw_decode", 3'd1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    tick();
    bus.mem_ready = 1'b0;
    chk("sw_exec", 3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
    tick();
    chk("sw_mem_wait", 3'd3, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
    tick();
    reset = 1'b1;
    chk("reset_mid_mem", 3'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    tick();
    chk("reset_held", 3'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    reset = 1'b0;
    chk("fetch_stall", 3'd0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    tick();
    chk("fetch_stall2", 3'd0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);

    // ADD; decoder fields change after DECODE to prove they are latched
    fetch("add_fetch");
    opcode = 6'b000000; funct = 6'b100000;
    chk("add_decode", 3'd1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    tick();
    opcode = 6'b111111; funct = 6'b101010;
    chk("add_exec", 3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
    tick();
    chk("add_wb", 3'd4, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 3'b000, 2'b00, 1, 0);
    tick();

    // SUB
    fetch("sub_fetch");
    opcode = 6'b000000; funct = 6'b100010;
    tick();
    chk("sub_exec", 3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b001, 2'b00, 0, 0);
    tick(); tick();

    // LW with two MEM wait cycles: 7 cycles total
    fetch("lw_fetch");
    opcode = 6'b100011; funct = 6'b000000;
    tick();
    bus.mem_ready = 1'b0;
    chk("lw_exec", 3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
    tick();
    chk("lw_mem_w1", 3'd3, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
    tick();
    chk("lw_mem_w2", 3'd3, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
    tick();
    bus.mem_ready = 1'b1;
    chk("lw_mem_rdy", 3'd3, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
    tick();
    chk("lw_wb", 3'd4, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 3'b000, 2'b01, 1, 0);
    tick();

    // SW zero-wait completes in MEM
    fetch("sw2_fetch");
    opcode = 6'b101011;
    tick(); tick();
    chk("sw2_mem", 3'd3, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b01, 1, 0);
    tick();

    // BEQ taken, BNE not taken with zero=1
    fetch("beq_fetch");
    opcode = 6'b000100;
    tick();
    zero = 1'b1;
    chk("beq_exec", 3'd2, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 3'b001, 2'b00, 1, 0);
    tick();
    fetch("bne_fetch");
    opcode = 6'b000101;
    tick();
    chk("bne_exec_z1", 3'd2, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 3'b001, 2'b00, 1, 0);
    tick();
    fetch("bne2_fetch");
    tick();
    zero = 1'b0;
    chk("bne_exec_z0", 3'd2, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 3'b001, 2'b00, 1, 0);
    tick();

    // XORI uses zero-extended immediate
    fetch("xori_fetch");
    opcode = 6'b001110;
    tick();
    chk("xori_exec", 3'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b011, 2'b10, 0, 0);
    tick();
    chk("xori_wb", 3'd4, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 3'b011, 2'b10, 1, 0);
    tick();

    // JAL and JR complete in DECODE
    fetch("jal_fetch");
    opcode = 6'b000011;
    chk("jal_decode", 3'd1, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b10, 3'b000, 2'b00, 1, 0);
    tick();
    fetch("jr_fetch");
    opcode = 6'b000000; funct = 6'b001000;
    chk("jr_decode", 3'd1, 0, 0, 0, 1, 2'b11, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);
    tick();

    // Illegal opcode, then R-type with unsupported funct
    fetch("ill_fetch");
    opcode = 6'b111111;
    chk("ill_opcode", 3'd1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);
    tick();
    fetch("ill2_fetch");
    opcode = 6'b000000; funct = 6'b000000;
    chk("ill_funct", 3'd1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);
    tick();
    bus.mem_ready = 1'b0;
    chk("ill_back_fetch", 3'd0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
